// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_64bit.sv
// Serializes a WIDTH-bit word loaded over a valid/ready handshake onto a
// single-bit valid/ready link, with back-to-back words and no idle bubble.
module piso_serializer_64bit
    import piso_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic                    serial_out,
    output logic                    serial_valid,
    input  logic                    serial_ready,
    output logic [cnt_w(WIDTH)-1:0] bits_left,
    output logic                    done
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [CW-1:0]    bits_nxt;
    logic             xfer, last_bit, load_acc;

    always_comb begin
        serial_valid = (state == SHIFT);
        xfer         = serial_valid && serial_ready;
        last_bit     = xfer && (bits_left == CW'(1));
        // Gated by reset so the source never sees ready while state is held clear
        load_ready   = !reset && ((state == IDLE) || last_bit);
        load_acc     = load_valid && load_ready;
        serial_out   = serial_valid && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);

        state_nxt = state;
        shift_nxt = shift_reg;
        bits_nxt  = bits_left;

        if (load_acc) begin
            state_nxt = SHIFT;
            shift_nxt = data_in;
            bits_nxt  = CW'(WIDTH);
        end else if (xfer) begin
            shift_nxt = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                  : {1'b0, shift_reg[WIDTH-1:1]};
            bits_nxt  = bits_left - CW'(1);
            if (last_bit) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bits_left <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bits_left <= bits_nxt;
            done      <= last_bit;
        end
    end

endmodule

// File: tb/tb_piso_serializer_64bit.sv
// Bench for piso_serializer_64bit: MSB-first and LSB-first instances driven in
// lockstep and compared every cycle against queue-based reference models.
module tb_piso_serializer_64bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] data_in;
    logic        load_valid;
    logic        serial_ready;

    logic        lr0, so0, sv0, dn0;
    logic [6:0]  bl0;
    logic        lr1, so1, sv1, dn1;
    logic [6:0]  bl1;

    int n_checks = 0;
    int n_fails  = 0;

    bit q0[$];
    bit q1[$];
    bit exp_done;

    piso_serializer_64bit #(.WIDTH(64), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(lr0), .serial_out(so0), .serial_valid(sv0),
        .serial_ready(serial_ready), .bits_left(bl0), .done(dn0)
    );

    piso_serializer_64bit #(.WIDTH(64), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(lr1), .serial_out(so1), .serial_valid(sv1),
        .serial_ready(serial_ready), .bits_left(bl1), .done(dn1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit sr);
        return (q0.size() == 0) || (q0.size() == 1 && sr);
    endfunction

    task automatic check_outputs();
        bit rdy;
        bit e0;
        bit e1;
        rdy = model_ready(serial_ready);
        e0  = (q0.size() != 0) ? q0[0] : 1'b0;
        e1  = (q1.size() != 0) ? q1[0] : 1'b0;
        check("msb load_ready",   64'(lr0), 64'(rdy));
        check("msb serial_valid", 64'(sv0), 64'(q0.size() != 0));
        check("msb serial_out",   64'(so0), 64'(e0));
        check("msb bits_left",    64'(bl0), 64'(q0.size()));
        check("msb done",         64'(dn0), 64'(exp_done));
        check("lsb load_ready",   64'(lr1), 64'(rdy));
        check("lsb serial_valid", 64'(sv1), 64'(q1.size() != 0));
        check("lsb serial_out",   64'(so1), 64'(e1));
        check("lsb bits_left",    64'(bl1), 64'(q1.size()));
        check("lsb done",         64'(dn1), 64'(exp_done));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " msb load_ready"},   64'(lr0), 64'd0);
        check({tag, " msb serial_valid"}, 64'(sv0), 64'd0);
        check({tag, " msb serial_out"},   64'(so0), 64'd0);
        check({tag, " msb bits_left"},    64'(bl0), 64'd0);
        check({tag, " msb done"},         64'(dn0), 64'd0);
        check({tag, " lsb serial_valid"}, 64'(sv1), 64'd0);
        check({tag, " lsb bits_left"},    64'(bl1), 64'd0);
        check({tag, " lsb done"},         64'(dn1), 64'd0);
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance
    // the model to what the coming rising edge must produce.
    task automatic step(input bit lv, input logic [63:0] d, input bit sr, output bit acc);
        bit rdy;
        bit xfer;
        bit last;
        @(negedge clk);
        load_valid   = lv;
        data_in      = d;
        serial_ready = sr;
        #1;
        check_outputs();
        rdy  = model_ready(sr);
        xfer = (q0.size() != 0) && sr;
        last = xfer && (q0.size() == 1);
        if (xfer) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        acc = lv && rdy;
        if (acc) begin
            for (int unsigned i = 0; i < 64; i++) begin
                q0.push_back(d[63 - i]);
                q1.push_back(d[i]);
            end
        end
        exp_done = last;
    endtask

    task automatic push_word(input logic [63:0] d);
        bit acc;
        int unsigned n;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 300) begin
            step(1'b1, d, 1'b1, acc);
            n++;
        end
        if (!acc) begin
            check("load accept timeout", 64'(acc), 64'd1);
        end
    endtask

    // mode 0: sink always ready, 1: alternating ready, 2: random ready
    task automatic run(input int unsigned cycles, input int unsigned mode);
        bit acc;
        bit sr;
        for (int unsigned i = 0; i < cycles; i++) begin
            case (mode)
                0:       sr = 1'b1;
                1:       sr = (i % 2 == 0);
                default: sr = ($urandom % 4) != 0;
            endcase
            step(1'b0, 64'd0, sr, acc);
        end
    endtask

    task automatic reset_mid_word();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        q0.delete();
        q1.delete();
        exp_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post reset msb load_ready", 64'(lr0), 64'd1);
        check("post reset lsb load_ready", 64'(lr1), 64'd1);
    endtask

    initial begin
        bit          acc;
        bit          holding;
        logic [63:0] rnd;

        reset        = 1'b0;
        load_valid   = 1'b0;
        data_in      = '0;
        serial_ready = 1'b0;
        exp_done     = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single word, MSB marker bits at both ends, full-rate sink
        push_word(64'h8000_0000_0000_0001);
        run(66, 0);

        // Alternating sink readiness stretches the word to 128 cycles
        push_word(64'h0000_0000_0000_00A5);
        run(132, 1);

        // Back-to-back words with load_valid held across the boundary
        push_word(64'd1);
        push_word(64'd2);
        run(66, 0);

        // Reset in the middle of a word, then a clean word afterwards
        push_word(64'hFFFF_FFFF_FFFF_FFFF);
        run(10, 0);
        reset_mid_word();
        push_word(64'd9);
        run(66, 0);

        // Word waiting behind an in-flight word with a stalling sink
        push_word(64'hDEAD_BEEF_0123_4567);
        run(5, 2);
        push_word(64'd3);
        run(66, 0);

        // LSB-first instance sees 1,0,1 then zeros
        push_word(64'd5);
        run(66, 0);

        // Randomized traffic; the source holds data until accepted
        holding = 1'b0;
        rnd     = '0;
        for (int unsigned c = 0; c < 3000; c++) begin
            if (!holding && ($urandom % 3) == 0) begin
                rnd     = {$urandom, $urandom};
                holding = 1'b1;
            end
            step(holding, holding ? rnd : 64'({$urandom, $urandom}), ($urandom % 4) != 0, acc);
            if (acc) begin
                holding = 1'b0;
            end
        end
        run(200, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/piso_serializer_64bit.md
Name: piso_serializer_64bit

Overview:
Parallel-in/serial-out reader for the 64-bit register path. It takes a WIDTH-bit word via a valid/ready load handshake and shifts it out one bit per accepted transfer on a valid/ready serial interface. It sits downstream of register_64bit and drains its data_out onto a single-bit link. It supports back-to-back words with no idle bubble.

Parameters:
WIDTH, 64, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  WIDTH  parallel word to serialise.
load_valid  input  1  data_in is valid.
load_ready  output  1  block can accept a word this cycle.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out is valid.
serial_ready  input  1  sink accepts serial_out this cycle.
bits_left  output  $clog2(WIDTH+1)  bits not yet transferred in the current word.
done  output  1  one-cycle pulse after the last bit of a word transfers.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- State: IDLE or SHIFT. Storage: WIDTH-bit shift_reg, bits_left counter, registered done.
- Reset assertion clears state, shift_reg, bits_left and done immediately, independent of clk.
  - Outputs during reset: serial_valid=0, serial_out=0, done=0, bits_left=0, load_ready=0.
  - load_ready is gated low while reset is high and rises combinationally on release (state=IDLE).
- load_ready = (state==IDLE) OR (state==SHIFT AND bits_left==1 AND serial_ready).
- Load accept:
  - Occurs on a clock edge when load_valid AND load_ready.
  - Effect: shift_reg <= data_in, bits_left <= WIDTH, state <= SHIFT.
  - The first bit is presented in the next cycle (load-to-first-bit latency 1 cycle).
- load_valid while load_ready=0: ignored. The source must hold data_in and load_valid until accepted.
- serial_valid = (state==SHIFT).
- serial_out = shift_reg[WIDTH-1] when MSB_FIRST=1, else shift_reg[0]. Forced to 0 in IDLE.
- Bit transfer: occurs on an edge with serial_valid AND serial_ready.
  - shift_reg shifts toward the output end with 0 fill; bits_left decrements by 1.
- No transfer (serial_ready=0): shift_reg, bits_left and serial_out all hold.
- Last bit (bits_left==1) transfers:
  - If load is accepted on the same edge, reload and stay in SHIFT; serial_valid never drops.
  - Otherwise state <= IDLE and bits_left <= 0.
  - In both cases done=1 for exactly the following cycle.
- Throughput: with serial_ready held high, a word occupies exactly WIDTH cycles. Back-to-back words run continuously.
- Reset mid-word: the word is discarded and no done pulse is produced.
- bits_left never wraps. It is WIDTH on load and 0 in IDLE.

Decomposition:
- Shared package piso_pkg holds:
  - state enum {IDLE, SHIFT};
  - constant function cnt_w(WIDTH) = $clog2(WIDTH+1).
- Single module; no sub-module is warranted (one shift register plus a counter).

Test Plan:
1. Reset, then load 64'h8000_0000_0000_0001 with MSB_FIRST=1 and serial_ready=1 -> serial_out 1, then 62 zeros, then 1. bits_left counts 64 down to 1. done=1 exactly one cycle after the 64th bit.
2. Load 64'h0000_0000_0000_00A5 with serial_ready toggling 1/0 -> bits advance only on ready cycles; serial_out and bits_left hold otherwise. Word completes in 128 cycles; LSB end reads 1010_0101.
3. Load 64'd1, then present 64'd2 with load_valid=1 throughout -> load_ready=1 only on the 64th-bit cycle. serial_valid stays high across the boundary; 128 bits are sent continuously; done pulses after bit 64 and after bit 128.
4. Assert reset after 10 bits of 64'hFFFF_FFFF_FFFF_FFFF -> serial_valid, bits_left and done drop to 0 immediately without a clock edge. After release, load_ready=1 and a load of 64'd9 serialises correctly.
5. During SHIFT, hold load_valid=1 with data_in=64'd3 -> load_ready=0 until the final bit. The in-flight word is unaffected; 64'd3 is accepted on the last-bit edge.
6. MSB_FIRST=0, load 64'd5 -> serial_out sequence 1,0,1 followed by 61 zeros.
